ps2_key_event_rx: RTL

Parametrised successor to the existing PS/2 keyboard receiver. It performs full 11-bit frame capture with parity, stop-bit and timeout checking. It decodes E0 (extended) and F0 (break) prefixes into single key events and buffers them in a FIFO drained with a valid/ready handshake. It sits between the PS2_CLK/PS2_DAT pins and game control logic, replacing the keyboard + oneshot pair.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_clk_filter.sv | 41 ++++
 rtl/ps2_key_event_rx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code constants, receiver FSM states and event layout for ps2_key_event_rx.
package ps2_pkg;

    localparam int EV_W = 10;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_NONE  = 8'h00;
    localparam logic [7:0] SC_ERR   = 8'hFF;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} ps2_state_e;

    // One-hot {up,down,left,right}; zero for non-arrow codes.
    function automatic logic [3:0] arrow_dir(input logic [7:0] code);
        return code == SC_UP    ? 4'b1000 :
               code == SC_DOWN  ? 4'b0100 :
               code == SC_LEFT  ? 4'b0010 :
               code == SC_RIGHT ? 4'b0001 : 4'b0000;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronises the PS/2 pins, debounces the clock over FILTER_LEN
// samples and emits a one-cycle strobe on each filtered falling edge.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic fall_stb,
    output logic dat
);

    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_s;
    logic [1:0]    dat_s;
    logic          filt;
    logic [FW-1:0] cnt;
    logic          flip;

    assign flip = clk_s[1] != filt && cnt == FW'(FILTER_LEN - 1);
    assign dat  = dat_s[1];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            clk_s    <= 2'b11;
            dat_s    <= 2'b11;
            filt     <= 1'b1;
            cnt      <= '0;
            fall_stb <= 1'b0;
        end else begin
            clk_s    <= {clk_s[0], ps2_clk};
            dat_s    <= {dat_s[0], ps2_dat};
            cnt      <= (clk_s[1] == filt || flip) ? '0 : cnt + 1'b1;
            filt     <= flip ? clk_s[1] : filt;
            fall_stb <= flip && filt;
        end
    end

endmodule

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: PS/2 frame receiver with E0/F0 prefix decode and an event FIFO.
// Optional arrow-key direction outputs when PS2_ARROW_DIR_EN is defined.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          iCLK,
    input  logic                          iRST_N,
    input  logic                          ps2_clk,
    input  logic                          ps2_dat,
    input  logic                          ev_ready,
    input  logic                          clr_err,
    output logic                          ev_valid,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err
`ifdef PS2_ARROW_DIR_EN
    ,
    output logic                          dir_stb,
    output logic [3:0]                    dir
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic            fall_stb;
    logic            dat;
    ps2_state_e      state;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic [7:0]      byte_q;
    logic            par;
    logic            byte_stb;
    logic [TW-1:0]   tcnt;
    logic            tmo;
    logic            stop_stb;
    logic            par_ok;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .fall_stb (fall_stb),
        .dat      (dat)
    );

    assign tmo      = state != S_IDLE && !fall_stb && tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign stop_stb = fall_stb && state == S_STOP;
    assign par_ok   = ^{shreg, par};

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= S_IDLE;
            bitcnt   <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            byte_q   <= '0;
            byte_stb <= 1'b0;
            tcnt     <= '0;
        end else begin
            byte_stb <= 1'b0;
            tcnt     <= (fall_stb || state == S_IDLE) ? '0 : tcnt + 1'b1;
            if (tmo) begin
                state <= S_IDLE;
                shreg <= '0;
            end else if (fall_stb) begin
                case (state)
                    S_IDLE: begin
                        state  <= dat ? S_IDLE : S_DATA;
                        bitcnt <= '0;
                    end
                    S_DATA: begin
                        shreg  <= {dat, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        state  <= bitcnt == 3'd7 ? S_PARITY : S_DATA;
                    end
                    S_PARITY: begin
                        par   <= dat;
                        state <= S_STOP;
                    end
                    S_STOP: begin
                        state    <= S_IDLE;
                        byte_stb <= dat && par_ok;
                        byte_q   <= (dat && par_ok) ? shreg : byte_q;
                    end
                endcase
            end
        end
    end

    logic             ext_pend;
    logic             brk_pend;
    logic             code_ok;
    logic             push;
    logic [EV_W-1:0]  din;
    logic [EV_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nx;
    logic [CW-1:0]    cnt_nx;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign code_ok = byte_q != SC_EXT && byte_q != SC_BRK && byte_q != SC_NONE && byte_q != SC_ERR;
    assign push    = byte_stb && code_ok;
    assign din     = {ext_pend, brk_pend, byte_q};
    assign full    = fifo_count == CW'(FIFO_DEPTH);
    assign pop     = ev_valid && ev_ready;
    assign wr_en   = push && (!full || pop);
    assign cnt_nx  = fifo_count + CW'(wr_en) - CW'(pop);
    assign rd_nx   = rd_ptr + AW'(pop);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (tmo) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (byte_stb) begin
            ext_pend <= byte_q == SC_EXT || (ext_pend && !code_ok);
            brk_pend <= byte_q == SC_BRK || (brk_pend && !code_ok);
        end
    end

    always_ff @(posedge iCLK) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end

    // Head register: a push into a slot that is about to become the head bypasses mem.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ev_valid   <= 1'b0;
            {ev_ext, ev_break, ev_code} <= '0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(wr_en);
            rd_ptr     <= rd_nx;
            fifo_count <= cnt_nx;
            ev_valid   <= cnt_nx != '0;
            if (cnt_nx != '0)
                {ev_ext, ev_break, ev_code} <= (wr_en && rd_nx == wr_ptr) ? din : mem[rd_nx];
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overflow   <= (push && full && !pop) || (overflow && !clr_err);
            parity_err <= (stop_stb && !par_ok) || (parity_err && !clr_err);
            frame_err  <= (stop_stb && !dat) || tmo || (frame_err && !clr_err);
        end
    end

`ifdef PS2_ARROW_DIR_EN
    assign dir_stb = push && ext_pend && !brk_pend && arrow_dir(byte_q) != 4'b0000;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            dir <= '0;
        else if (dir_stb)
            dir <= arrow_dir(byte_q);
    end
`endif

endmodule
